// File: rtl/darksocv_uart_pkg.sv
// darksocv_uart_pkg: shared UART receiver state encoding and default bit timing.
package darksocv_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
    localparam int BAUD_DIV_DEFAULT = 868;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO; a push into a full FIFO succeeds only alongside a pop.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push_i,
    input  logic [7:0]                        data_i,
    input  logic                              pop_i,
    output logic [7:0]                        data_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    output logic                              full_o,
    output logic                              empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH+1);
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [NW-1:0] cnt_q;
    logic          do_pop, do_push;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign full_o  = cnt_q == NW'(FIFO_DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    // Head reads as zero while empty so the port is defined out of reset.
    assign data_o  = empty_o ? 8'h00 : mem_q[rp_q];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= do_push ? wp_q + AW'(1) : wp_q;
            rp_q  <= do_pop ? rp_q + AW'(1) : rp_q;
            cnt_q <= cnt_q + NW'(do_push) - NW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= data_i;
    end
endmodule

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 UART receiver sampling at mid-bit, buffering bytes in a FIFO
// with sticky overrun and framing-error flags.
module uart_rx_capture import darksocv_uart_pkg::*; #(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              XCLK,
    input  logic                              XRES,
    input  logic                              RXD,
    input  logic                              RD_EN,
    input  logic                              CLR_ERR,
    output logic [7:0]                        RD_DATA,
    output logic                              RD_VALID,
    output logic                              FULL,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   COUNT,
    output logic                              OVERRUN,
    output logic                              FERR
);
    localparam int CW = $clog2(BAUD_DIV);
    rx_state_e     state_q;
    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          ferr_q, ovr_q, rx, prev, push, drop, empty;
    // Two synchronizer stages plus one history stage for falling-edge detection.
    assign rx   = sync_q[1];
    assign prev = sync_q[2];
    assign push = (state_q == STOP) && (cnt_q == '0) && rx;
    assign drop = push && FULL && !RD_EN;
    assign RD_VALID = !empty;
    assign OVERRUN  = ovr_q;
    assign FERR     = ferr_q;
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) sync_q <= 3'b111;
        else       sync_q <= {sync_q[1:0], RXD};
    end
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (CLR_ERR) begin
                ferr_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
            if (drop) ovr_q <= 1'b1;
            case (state_q)
                IDLE: if (prev && !rx) begin
                    state_q <= START;
                    cnt_q   <= CW'(BAUD_DIV/2-1);
                end
                START: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                    else if (rx) state_q <= IDLE;
                    else begin
                        state_q <= DATA;
                        cnt_q   <= CW'(BAUD_DIV-1);
                        bit_q   <= '0;
                    end
                DATA: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                    else begin
                        sh_q  <= {rx, sh_q[7:1]};
                        cnt_q <= CW'(BAUD_DIV-1);
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end
                STOP: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                    else begin
                        state_q <= IDLE;
                        if (!rx) ferr_q <= 1'b1;
                    end
                default: state_q <= IDLE;
            endcase
        end
    end
    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (XCLK),
        .rst_n   (XRES),
        .push_i  (push),
        .data_i  (sh_q),
        .pop_i   (RD_EN),
        .data_o  (RD_DATA),
        .count_o (COUNT),
        .full_o  (FULL),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: directed frames; a scoreboard queue holds expected bytes and a monitor checks every pop.
module tb_uart_rx_capture;
    logic       XCLK, XRES, RXD, RD_EN, CLR_ERR;
    logic [7:0] RD_DATA;
    logic       RD_VALID, FULL, OVERRUN, FERR;
    logic [4:0] COUNT;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];

    uart_rx_capture #(.BAUD_DIV(16), .FIFO_DEPTH(16)) dut (
        .XCLK(XCLK), .XRES(XRES), .RXD(RXD), .RD_EN(RD_EN), .CLR_ERR(CLR_ERR),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .FULL(FULL), .COUNT(COUNT),
        .OVERRUN(OVERRUN), .FERR(FERR)
    );

    initial XCLK = 1'b0;
    always #5 XCLK = ~XCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge XCLK) begin
        if (XRES && RD_EN && RD_VALID) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got=%02h exp=none", RD_DATA);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (RD_DATA !== e) begin
                    failures++;
                    $display("FAIL pop_data got=%02h exp=%02h", RD_DATA, e);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge XCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            wait_cyc(16);
        end
        RXD = stop;
        wait_cyc(16);
        RXD = 1'b1;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            RD_EN = 1'b1;
            wait_cyc(1);
        end
        RD_EN = 1'b0;
    endtask

    initial begin
        int lat;
        XRES = 1'b0; RXD = 1'b1; RD_EN = 1'b0; CLR_ERR = 1'b0;
        wait_cyc(3);
        chk("rst_valid", RD_VALID, 0);
        chk("rst_full", FULL, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_overrun", OVERRUN, 0);
        chk("rst_ferr", FERR, 0);
        chk("rst_data", RD_DATA, 8'h00);
        XRES = 1'b1;
        wait_cyc(3);

        sb.push_back(8'h55);
        lat = 0;
        fork
            send_byte(8'h55, 1'b1);
            begin
                while (!RD_VALID && lat < 400) begin
                    @(posedge XCLK);
                    #2;
                    lat++;
                end
            end
        join
        chk("latency_0x55", lat, 155);
        chk("count_0x55", COUNT, 1);
        chk("head_0x55", RD_DATA, 8'h55);
        chk("flags_0x55", {OVERRUN, FERR}, 2'b00);
        pop_n(1);
        chk("count_after_pop", COUNT, 0);

        RXD = 1'b0;
        wait_cyc(4);
        RXD = 1'b1;
        wait_cyc(20);
        chk("glitch_count", COUNT, 0);
        chk("glitch_ferr", FERR, 0);
        sb.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_cyc(2);
        chk("post_glitch_count", COUNT, 1);
        pop_n(1);

        send_byte(8'hA3, 1'b0);
        wait_cyc(16);
        chk("ferr_set", FERR, 1);
        chk("ferr_count", COUNT, 0);
        CLR_ERR = 1'b1;
        wait_cyc(1);
        CLR_ERR = 1'b0;
        wait_cyc(1);
        chk("ferr_clear", FERR, 0);

        for (int i = 0; i <= 16; i++) begin
            if (i < 16) sb.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        wait_cyc(2);
        chk("fill_full", FULL, 1);
        chk("fill_overrun", OVERRUN, 1);
        chk("fill_count", COUNT, 16);
        pop_n(16);
        chk("drain_count", COUNT, 0);
        CLR_ERR = 1'b1;
        wait_cyc(1);
        CLR_ERR = 1'b0;
        chk("overrun_clear", OVERRUN, 0);

        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'(8'h20 + i));
            send_byte(8'(8'h20 + i), 1'b1);
        end
        sb.push_back(8'h7E);
        fork
            send_byte(8'h7E, 1'b1);
            begin
                wait_cyc(154);
                RD_EN = 1'b1;
                wait_cyc(1);
                RD_EN = 1'b0;
            end
        join
        wait_cyc(2);
        chk("rdpush_count", COUNT, 16);
        chk("rdpush_overrun", OVERRUN, 0);
        chk("rdpush_full", FULL, 1);
        pop_n(16);
        chk("rdpush_drained", COUNT, 0);

        fork
            send_byte(8'hFF, 1'b1);
            begin
                wait_cyc(85);
                XRES = 1'b0;
                wait_cyc(3);
                XRES = 1'b1;
            end
        join
        wait_cyc(20);
        chk("midreset_count", COUNT, 0);
        sb.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        wait_cyc(2);
        chk("after_reset_count", COUNT, 1);
        chk("after_reset_head", RD_DATA, 8'h12);
        pop_n(1);
        wait_cyc(2);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
